// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: handshaked code-word capture, LSB-first symbol
// serialization, traceback start and traceback timeout supervision.
module viterbi_frame_ctrl #(
  parameter int unsigned SIZE_DATA_IN = 16,
  parameter int unsigned SIZE_SYMBOL  = 2,
  parameter int unsigned FRAME_WORDS  = 4,
  parameter int unsigned TB_TIMEOUT   = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_abort,
  input  logic                    i_word_valid,
  input  logic [SIZE_DATA_IN-1:0] i_word,
  output logic                    o_word_ready,
  output logic                    o_sym_valid,
  output logic [SIZE_SYMBOL-1:0]  o_sym,
  output logic                    o_sym_first,
  input  logic                    i_dec_ready,
  output logic                    o_tb_start,
  input  logic                    i_tb_done,
  output logic                    o_frame_done,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int unsigned DEPTH = SIZE_DATA_IN / SIZE_SYMBOL;
  localparam int unsigned SIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned TMW   = $clog2(TB_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_TRACE,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [SIZE_DATA_IN-1:0] word_q, word_d;
  logic [SIW-1:0]          sym_idx_q, sym_idx_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [TMW-1:0]          tmo_q, tmo_d;
  logic                    first_q, first_d;
  logic                    err_d;
  logic                    rdy_q;
  logic                    accept_c;
  logic                    shift_d;
  logic [SIZE_SYMBOL-1:0]  sym_d;

  // Only the word-ready handshake may see an input combinationally (abort gate).
  assign o_word_ready = rdy_q & ~i_abort;
  assign accept_c     = i_word_valid & o_word_ready;

  assign shift_d = (state_d == ST_SHIFT);
  assign sym_d   = SIZE_SYMBOL'(word_d >> (SIZE_SYMBOL * 32'(sym_idx_d)));

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    sym_idx_d  = sym_idx_q;
    word_cnt_d = word_cnt_q;
    first_d    = first_q;
    tmo_d      = tmo_q;
    err_d      = o_err;

    if (i_abort) begin
      state_d    = ST_IDLE;
      sym_idx_d  = '0;
      word_cnt_d = '0;
      tmo_d      = '0;
      first_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            word_d     = i_word;
            sym_idx_d  = '0;
            word_cnt_d = '0;
            first_d    = 1'b1;
            state_d    = ST_SHIFT;
          end
        end
        ST_LOAD: begin
          if (accept_c) begin
            word_d    = i_word;
            sym_idx_d = '0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_dec_ready) begin
            if (sym_idx_q == SIW'(DEPTH - 1)) begin
              sym_idx_d = '0;
              first_d   = 1'b0;
              if (word_cnt_q == WCW'(FRAME_WORDS - 1)) begin
                tmo_d   = '0;
                state_d = ST_TRACE;
              end else begin
                word_cnt_d = word_cnt_q + WCW'(1);
                state_d    = ST_LOAD;
              end
            end else begin
              sym_idx_d = sym_idx_q + SIW'(1);
            end
          end
        end
        ST_TRACE: begin
          tmo_d = tmo_q + TMW'(1);
          if (i_tb_done) begin
            state_d = ST_DONE;
          end else if (tmo_q == TMW'(TB_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          tmo_d      = '0;
          word_cnt_d = '0;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs; outputs are decoded from next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      sym_idx_q    <= '0;
      word_cnt_q   <= '0;
      tmo_q        <= '0;
      first_q      <= 1'b0;
      rdy_q        <= 1'b1;
      o_sym_valid  <= 1'b0;
      o_sym        <= '0;
      o_sym_first  <= 1'b0;
      o_tb_start   <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      sym_idx_q    <= sym_idx_d;
      word_cnt_q   <= word_cnt_d;
      tmo_q        <= tmo_d;
      first_q      <= first_d;
      rdy_q        <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      o_sym_valid  <= shift_d;
      o_sym        <= shift_d ? sym_d : '0;
      o_sym_first  <= shift_d && first_d && (sym_idx_d == '0);
      o_tb_start   <= (state_d == ST_TRACE) && (state_q != ST_TRACE);
      o_frame_done <= (state_d == ST_DONE);
      o_busy       <= (state_d != ST_IDLE);
      o_err        <= err_d;
    end
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the Viterbi decoder datapath. It accepts 16-bit packed code words over a valid/ready handshake and serializes each word into 2-bit received symbols, LSB pair first, for the branch-metric/ACS stage. It counts words per frame, starts traceback after the last symbol, and watches for traceback completion with a timeout. It sits between the input word interface and the decoder core, and replaces free-running serializer control with a handshaked, frame-aware sequence.

## Interface
- SIZE_DATA_IN, 16, packed code word width
- SIZE_SYMBOL, 2, symbol width (bits per trellis step); SIZE_DATA_IN must be a multiple of it
- FRAME_WORDS, 4, code words per frame (≥1)
- TB_TIMEOUT, 64, max cycles to wait for i_tb_done (≥1)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_abort  in  1  synchronous frame abort
- i_word_valid  in  1  code word offered
- i_word  in  SIZE_DATA_IN  code word
- o_word_ready  out  1  controller can take a word
- o_sym_valid  out  1  symbol presented to decoder
- o_sym  out  SIZE_SYMBOL  received symbol
- o_sym_first  out  1  first symbol of frame (decoder resets path metrics)
- i_dec_ready  in  1  decoder accepts symbol this cycle
- o_tb_start  out  1  one-cycle traceback start pulse
- i_tb_done  in  1  traceback finished
- o_frame_done  out  1  one-cycle pulse, frame completed
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  sticky traceback timeout flag

## Operation
- DEPTH = SIZE_DATA_IN/SIZE_SYMBOL. Counters: sym_idx $clog2(DEPTH) bits, word_cnt max(1,$clog2(FRAME_WORDS)) bits, tmo_cnt $clog2(TB_TIMEOUT+1) bits. All wrap-free: each is cleared before reaching its terminal value +1.
- States: IDLE, LOAD, SHIFT, TRACE, DONE.
- IDLE: o_word_ready=1. On i_word_valid & o_word_ready, register the word, sym_idx=0, word_cnt=0, set first flag, go to SHIFT.
- LOAD (subsequent words in frame): o_word_ready=1, same capture, go to SHIFT. The frame is still open, so the controller waits indefinitely here.
- SHIFT: o_sym_valid=1, o_sym = word[SIZE_SYMBOL*sym_idx +: SIZE_SYMBOL], o_sym_first = first flag & sym_idx==0.
  - Advance only on i_dec_ready=1. If i_dec_ready=0, hold o_sym and o_sym_first stable.
  - On acceptance of sym_idx==DEPTH-1: clear the first flag.
    - If word_cnt==FRAME_WORDS-1, go to TRACE and clear tmo_cnt.
    - Otherwise increment word_cnt and go to LOAD.
- TRACE: o_tb_start=1 in the first TRACE cycle only. Each cycle tmo_cnt++.
  - i_tb_done=1 → DONE.
  - tmo_cnt==TB_TIMEOUT-1 without done → set o_err, go to DONE.
  - i_tb_done in the o_tb_start cycle is accepted.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- i_abort=1 (any state): next state IDLE. Counters and first flag are cleared, no o_frame_done, o_err is unchanged. A word offered in the abort cycle is not accepted: o_word_ready is forced to 0 that cycle.
- i_rst: same as abort, plus clears o_err and the word register. i_rst has priority over all inputs.
- Reset values: o_word_ready=1 (IDLE), o_sym_valid=0, o_sym=0, o_sym_first=0, o_tb_start=0, o_frame_done=0, o_busy=0, o_err=0.
- All outputs are decoded from registered state/counters only. There is no combinational path from any input to any output, except o_word_ready gated by i_abort.
- o_sym=0 whenever o_sym_valid=0.

## Timing
- Word accepted in cycle N → first symbol valid in cycle N+1.
- With i_dec_ready held high, symbols occupy N+1..N+DEPTH. Next o_word_ready is in N+DEPTH+1 (one bubble per word).
- Last word of frame: o_tb_start in cycle N+DEPTH+1.
- i_tb_done high in cycle M → o_frame_done in M+1 → o_word_ready in M+2.
- Timeout: o_tb_start cycle T → o_err and o_frame_done assert at T+TB_TIMEOUT.
- Best-case frame length with defaults: 4×9 + 3 cycles from first accept to IDLE.

## Test plan
- Reset, then a single frame (FRAME_WORDS=4) of words 0xE4E4, 0x0000, 0xFFFF, 0x1B1B with i_dec_ready=1 and i_tb_done returned 5 cycles after o_tb_start → 32 symbols.
  - First word yields o_sym = 0,1,2,3,0,1,2,3.
  - o_sym_first high only on symbol 0.
  - o_tb_start one cycle after symbol 31.
  - o_frame_done one cycle after done; o_err=0.
- Backpressure: i_dec_ready toggling 1,0,0,1 during word 0xE4E4 → each symbol held stable while stalled. Symbol sequence is unchanged, and no symbol is duplicated or dropped.
- Timeout: TB_TIMEOUT=64, i_tb_done never asserted → o_err and o_frame_done rise exactly 64 cycles after o_tb_start. o_err stays high across the next frame and clears only on i_rst.
- Abort mid-SHIFT at word 2, symbol 3 → IDLE next cycle. o_sym_valid=0, no o_tb_start, no o_frame_done. The next word accepted asserts o_sym_first.
- Simultaneous i_word_valid and i_abort in IDLE → word not accepted (o_word_ready=0). Acceptance happens the following cycle.
- i_rst asserted during TRACE with o_err=1 → all outputs at reset values one cycle later, o_err=0, and i_tb_done is ignored afterward.
